sid_reg_read: RTL and testbench



---
 rtl/sid_reg_read_pkg.sv | 25 ++
 rtl/sid_reg_read_if.sv | 15 +
 rtl/sid_pot_adc.sv | 54 +++++
 rtl/sid_reg_read.sv | 111 +++++++++++
 tb/tb_sid_reg_read.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sid_reg_read_pkg.sv
// Shared constants and types for the SID register read-back path.
package sid_reg_read_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DECAY_W     = 16;
  localparam int unsigned POT_PHASE_W = 9;
  localparam int unsigned POT_HALF    = 256;

  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [DECAY_W-1:0]     decay_t;
  typedef logic [POT_PHASE_W-1:0] potPhase_t;

  localparam addr_t REG_POTX = 5'h19;
  localparam addr_t REG_POTY = 5'h1A;
  localparam addr_t REG_OSC3 = 5'h1B;
  localparam addr_t REG_ENV3 = 5'h1C;

  // Discharge half of the pot cycle is the lower half of the phase range.
  function automatic logic isDischarge(input potPhase_t phase);
    return phase < POT_PHASE_W'(POT_HALF);
  endfunction

endpackage

// File: rtl/sid_reg_read_if.sv
// CPU register bus shared with the SID write decoders, plus read-back response.
interface sid_reg_read_if;
  import sid_reg_read_pkg::*;

  logic  iWE;
  logic  iRE;
  addr_t iAddr;
  data_t iData;
  data_t oData;
  logic  oValid;

  modport master (output iWE, iRE, iAddr, iData, input oData, oValid);
  modport slave  (input iWE, iRE, iAddr, iData, output oData, oValid);

endinterface

// File: rtl/sid_pot_adc.sv
// One paddle channel: counts clkEn ticks until the comparator trips during
// the charge half of the pot cycle, and publishes the count at the wrap.
module sid_pot_adc
  import sid_reg_read_pkg::*;
(
  input  logic      clk,
  input  logic      iRst,
  input  logic      clkEn,
  input  potPhase_t iPhase,
  input  logic      iComp,
  output data_t     oResult
);

  data_t count;
  data_t countNxt;
  logic  crossed;
  logic  crossedNxt;
  data_t resultNxt;

  // Count/freeze on each tick; result sees this tick's sample at phase 511.
  always_comb begin
    countNxt   = count;
    crossedNxt = crossed;
    resultNxt  = oResult;
    if (clkEn) begin
      if (isDischarge(iPhase)) begin
        countNxt   = '0;
        crossedNxt = 1'b0;
      end else if (!crossed) begin
        if (iComp) begin
          crossedNxt = 1'b1;
        end else if (count != '1) begin
          countNxt = count + DATA_W'(1);
        end
      end
      if (iPhase == '1) begin
        resultNxt = crossedNxt ? countNxt : '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      count   <= '0;
      crossed <= 1'b0;
      oResult <= '0;
    end else begin
      count   <= countNxt;
      crossed <= crossedNxt;
      oResult <= resultNxt;
    end
  end

endmodule

// File: rtl/sid_reg_read.sv
// SID read-back: POTX/POTY/OSC3/ENV3 registers, decaying data-bus latch for
// write-only addresses, and the shared pot phase/discharge control.
module sid_reg_read
  import sid_reg_read_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned DECAY_TICKS = 2000
) (
  input  logic  clk,
  input  logic  iRst,
  input  logic  clkEn,
  input  data_t iOsc3,
  input  data_t iEnv3,
  input  logic  iPotX,
  input  logic  iPotY,
  output logic  oPotDischarge,
  sid_reg_read_if.slave bus
);

  addr_t     offset;
  logic      rdEn;
  logic      isRoReg;
  data_t     rdVal;
  data_t     busLatch;
  data_t     busLatchNxt;
  decay_t    decayCnt;
  decay_t    decayCntNxt;
  potPhase_t phase;
  potPhase_t phaseNxt;
  data_t     potXResult;
  data_t     potYResult;

  sid_pot_adc uPotX (
    .clk     (clk),
    .iRst    (iRst),
    .clkEn   (clkEn),
    .iPhase  (phase),
    .iComp   (iPotX),
    .oResult (potXResult)
  );

  sid_pot_adc uPotY (
    .clk     (clk),
    .iRst    (iRst),
    .clkEn   (clkEn),
    .iPhase  (phase),
    .iComp   (iPotY),
    .oResult (potYResult)
  );

  // Read decode; a write in the same cycle suppresses the read.
  always_comb begin
    offset  = bus.iAddr - ADDR_W'(BASE_ADDR);
    rdEn    = bus.iRE & ~bus.iWE;
    isRoReg = 1'b1;
    rdVal   = busLatch;
    case (offset)
      REG_POTX: rdVal = potXResult;
      REG_POTY: rdVal = potYResult;
      REG_OSC3: rdVal = iOsc3;
      REG_ENV3: rdVal = iEnv3;
      default:  isRoReg = 1'b0;
    endcase
  end

  // Bus latch: any load wins over a decay tick in the same cycle.
  always_comb begin
    busLatchNxt = busLatch;
    decayCntNxt = decayCnt;
    if (bus.iWE) begin
      busLatchNxt = bus.iData;
      decayCntNxt = DECAY_W'(DECAY_TICKS);
    end else if (rdEn && isRoReg) begin
      busLatchNxt = rdVal;
      decayCntNxt = DECAY_W'(DECAY_TICKS);
    end else if (clkEn && decayCnt != '0) begin
      decayCntNxt = decayCnt - DECAY_W'(1);
      if (decayCnt == DECAY_W'(1)) begin
        busLatchNxt = '0;
      end
    end
  end

  always_comb begin
    phaseNxt = phase;
    if (clkEn) begin
      phaseNxt = phase + POT_PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      bus.oData     <= '0;
      bus.oValid    <= 1'b0;
      busLatch      <= '0;
      decayCnt      <= '0;
      phase         <= '0;
      oPotDischarge <= 1'b1;
    end else begin
      bus.oValid    <= rdEn;
      if (rdEn) begin
        bus.oData <= rdVal;
      end
      busLatch      <= busLatchNxt;
      decayCnt      <= decayCntNxt;
      phase         <= phaseNxt;
      oPotDischarge <= isDischarge(phaseNxt);
    end
  end

endmodule

// File: tb/tb_sid_reg_read.sv
// Directed bench for sid_reg_read; reads are scored through an expectation queue.
module tb_sid_reg_read;
  import sid_reg_read_pkg::*;

  localparam int unsigned DECAY = 2000;

  logic  clk = 1'b0;
  logic  iRst;
  logic  clkEn;
  data_t iOsc3;
  data_t iEnv3;
  logic  iPotX;
  logic  iPotY;
  logic  oPotDischarge;

  sid_reg_read_if bus();

  sid_reg_read #(.BASE_ADDR(0), .DECAY_TICKS(DECAY)) dut (
    .clk           (clk),
    .iRst          (iRst),
    .clkEn         (clkEn),
    .iOsc3         (iOsc3),
    .iEnv3         (iEnv3),
    .iPotX         (iPotX),
    .iPotY         (iPotY),
    .oPotDischarge (oPotDischarge),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int    nTests = 0;
  int    nFail  = 0;
  data_t expQ[$];
  logic  prevValid = 1'b0;
  int    tbPhase = 0;
  int    potXTh = 512;
  int    potYTh = 512;
  int    dischargeCnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every oValid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.oValid === 1'b1) begin
      nTests++;
      if (prevValid) begin
        nFail++;
        $display("FAIL valid_width: oValid high 2 cycles, expected 1");
      end else if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_valid: got oData=0x%0h, expected no response", bus.oData);
      end else begin
        data_t e;
        e = expQ.pop_front();
        if (bus.oData !== e) begin
          nFail++;
          $display("FAIL read_data: got 0x%0h, expected 0x%0h", bus.oData, e);
        end
      end
    end
    prevValid = bus.oValid;
  end

  // One clkEn tick spread over two clk cycles; comparators follow the phase mirror.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      iPotX = (tbPhase >= potXTh);
      iPotY = (tbPhase >= potYTh);
      if (oPotDischarge) dischargeCnt++;
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      tbPhase = (tbPhase + 1) % 512;
      @(negedge clk);
    end
  endtask

  task automatic rd(input addr_t a, input data_t e);
    bus.iAddr = a;
    bus.iRE   = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    bus.iRE = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input addr_t a, input data_t d);
    bus.iAddr = a;
    bus.iData = d;
    bus.iWE   = 1'b1;
    @(negedge clk);
    bus.iWE = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; clkEn = 1'b0; iOsc3 = '0; iEnv3 = '0; iPotX = 1'b0; iPotY = 1'b0;
    bus.iWE = 1'b0; bus.iRE = 1'b0; bus.iAddr = '0; bus.iData = '0;
    repeat (3) @(negedge clk);
    iRst = 1'b0;
    chk("reset_oData", int'(bus.oData), 0);
    chk("reset_oValid", int'(bus.oValid), 0);
    chk("reset_discharge", int'(oPotDischarge), 1);

    // ENV3 read: one-cycle latency, one-cycle pulse
    iEnv3 = 8'h5A;
    bus.iAddr = REG_ENV3;
    bus.iRE = 1'b1;
    expQ.push_back(8'h5A);
    @(negedge clk);
    bus.iRE = 1'b0;
    chk("env3_valid_hi", int'(bus.oValid), 1);
    @(negedge clk);
    chk("env3_valid_lo", int'(bus.oValid), 0);
    chk("env3_data_hold", int'(bus.oData), 'h5A);

    // Latch decay around the DECAY boundary
    wr(5'h12, 8'hA5);
    tick(10);
    rd(5'h05, 8'hA5);
    tick(DECAY - 11);
    rd(5'h05, 8'hA5);
    tick(1);
    rd(5'h05, 8'h00);

    // Reading OSC3 refreshes the latch
    iOsc3 = 8'h3C;
    rd(REG_OSC3, 8'h3C);
    iOsc3 = 8'h99;
    tick(3);
    rd(5'h00, 8'h3C);

    // Simultaneous write and read: write only
    bus.iAddr = 5'h04;
    bus.iData = 8'h77;
    bus.iWE = 1'b1;
    bus.iRE = 1'b1;
    @(negedge clk);
    bus.iWE = 1'b0;
    bus.iRE = 1'b0;
    @(negedge clk);
    rd(5'h00, 8'h77);

    // Pot cycle 1: POTX trips on count tick 101, POTY never
    tick((512 - tbPhase) % 512);
    potXTh = 356;
    potYTh = 512;
    dischargeCnt = 0;
    tick(512);
    chk("discharge_ticks", dischargeCnt, 256);
    rd(REG_POTX, 8'h64);
    rd(REG_POTY, 8'hFF);

    // Pot cycle 2: POTX high on first count tick, POTY on tick 45
    potXTh = 256;
    potYTh = 300;
    tick(512);
    potXTh = 512;
    potYTh = 512;
    rd(REG_POTX, 8'h00);
    rd(REG_POTY, 8'h2C);
    rd(5'h1F, 8'h2C);

    // Reset mid-decay, with a read strobe dropped by the reset
    wr(5'h00, 8'hC3);
    tick(5);
    iRst = 1'b1;
    bus.iAddr = 5'h00;
    bus.iRE = 1'b1;
    @(negedge clk);
    iRst = 1'b0;
    bus.iRE = 1'b0;
    tbPhase = 0;
    chk("rst_discharge", int'(oPotDischarge), 1);
    chk("rst_oValid", int'(bus.oValid), 0);
    @(negedge clk);
    rd(5'h00, 8'h00);
    rd(REG_POTX, 8'h00);

    repeat (4) @(negedge clk);
    chk("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
